// File: rtl/cotm32_pkg.sv
// rtl/cotm32_pkg.sv - shared cotm32 core types and constants used by the fetch stage
package cotm32_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  // Instruction memory window; the reset vector is its first word.
  localparam logic [XLEN-1:0] INST_MEM_START = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_MEM_END   = 32'h0000_00FF;
  localparam logic [XLEN-1:0] RESET_VECTOR   = INST_MEM_START;

  // addi x0,x0,0
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [3:0] EXC_INST_MISALIGNED   = 4'd0;
  localparam logic [3:0] EXC_INST_ACCESS_FAULT = 4'd1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [INST_WIDTH-1:0] inst;
    logic                  exc_valid;
    logic [3:0]            exc_cause;
  } if_id_t;

  // Empty IF/ID entry; identical to the reset contents of the register.
  localparam if_id_t IF_ID_BUBBLE = '{
    valid:     1'b0,
    pc:        '0,
    pc_plus4:  '0,
    inst:      NOP_INST,
    exc_valid: 1'b0,
    exc_cause: 4'd0
  };

endpackage

// File: rtl/inst_fetch_check.sv
// rtl/inst_fetch_check.sv - combinational fetch-address misalignment and range check
module fetch_check
  import cotm32_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  output logic            o_exc_valid,
  output logic [3:0]      o_exc_cause
);

  logic            misaligned;
  logic            fault;
  logic [XLEN-1:0] offset;

  // Offset from the window base: an address below the base wraps to a huge
  // offset, so one unsigned compare covers both ends of the window.
  assign offset     = i_pc - INST_MEM_START;
  assign misaligned = (i_pc[1:0] != 2'b00);
  assign fault      = (offset > (INST_MEM_END - INST_MEM_START - 32'd3));

  // Misalignment takes precedence when both conditions hold.
  always_comb begin
    o_exc_valid = misaligned | fault;
    o_exc_cause = misaligned ? EXC_INST_MISALIGNED : EXC_INST_ACCESS_FAULT;
    if (!(misaligned | fault)) begin
      o_exc_cause = 4'd0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - cotm32 instruction fetch stage with IF/ID pipeline register
module inst_fetch
  import cotm32_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [XLEN-1:0]       o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  input  logic                  i_stall,
  input  logic                  i_redirect_valid,
  input  logic [XLEN-1:0]       i_redirect_pc,
  input  logic                  i_trap_valid,
  input  logic [XLEN-1:0]       i_trap_pc,
  output logic                  o_id_valid,
  output logic [XLEN-1:0]       o_id_pc,
  output logic [XLEN-1:0]       o_id_pc_plus4,
  output logic [INST_WIDTH-1:0] o_id_inst,
  output logic                  o_id_exc_valid,
  output logic [3:0]            o_id_exc_cause,
  output logic [31:0]           o_fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic [31:0]     count_q, count_d;

  logic            chk_exc_valid;
  logic [3:0]      chk_exc_cause;
  logic [XLEN-1:0] pc_plus4;

  fetch_check u_fetch_check (
    .i_pc        (pc_q),
    .o_exc_valid (chk_exc_valid),
    .o_exc_cause (chk_exc_cause)
  );

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection: trap > redirect > stall > fetch (reset handled in the register).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_id_d = if_id_q;
    count_d = count_q;

    if (i_trap_valid || i_redirect_valid) begin
      // The word at the old pc is dropped, leaving one bubble behind the redirect.
      pc_d    = i_trap_valid ? i_trap_pc : i_redirect_pc;
      if_id_d = IF_ID_BUBBLE;
      state_d = RUN;
    end else if (i_stall) begin
      // hold everything
    end else if (state_q == HALTED) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (chk_exc_valid) begin
      // Deliver the exception once, then park until control flow is redirected.
      if_id_d.valid     = 1'b1;
      if_id_d.pc        = pc_q;
      if_id_d.pc_plus4  = pc_plus4;
      if_id_d.inst      = NOP_INST;
      if_id_d.exc_valid = 1'b1;
      if_id_d.exc_cause = chk_exc_cause;
      state_d           = HALTED;
    end else begin
      if_id_d.valid     = 1'b1;
      if_id_d.pc        = pc_q;
      if_id_d.pc_plus4  = pc_plus4;
      if_id_d.inst      = i_imem_inst;
      if_id_d.exc_valid = 1'b0;
      if_id_d.exc_cause = 4'd0;
      pc_d              = pc_plus4;
      count_d           = count_q + 32'd1;
    end
  end

  // State, pc, IF/ID and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      if_id_q <= IF_ID_BUBBLE;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      count_q <= count_d;
    end
  end

  assign o_imem_addr    = pc_q;
  assign o_id_valid     = if_id_q.valid;
  assign o_id_pc        = if_id_q.pc;
  assign o_id_pc_plus4  = if_id_q.pc_plus4;
  assign o_id_inst      = if_id_q.inst;
  assign o_id_exc_valid = if_id_q.exc_valid;
  assign o_id_exc_cause = if_id_q.exc_cause;
  assign o_fetch_count  = count_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the cotm32 core.
- Owns the program counter and drives the address of the combinational instruction memory. The memory returns the instruction word in the same cycle.
- Registers the fetched instruction into the IF/ID pipeline register for the decoder.
- Handles stall, control-flow redirect, trap entry and fetch-side exceptions (misaligned PC, PC outside instruction memory).

Parameters:
- RESET_VECTOR, INST_MEM_START (from cotm32_pkg), PC loaded on reset.
- NOP_INST, 32'h0000_0013 (addi x0,x0,0), instruction word placed in IF/ID when no valid instruction is held.

Ports:
- i_clk  input  1  core clock, all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- o_imem_addr  output  XLEN  fetch address to instruction memory; always equals current PC.
- i_imem_inst  input  INST_WIDTH  instruction word returned combinationally for o_imem_addr.
- i_stall  input  1  hazard-unit stall; hold PC and IF/ID.
- i_redirect_valid  input  1  branch/jump taken, from execute.
- i_redirect_pc  input  XLEN  redirect target.
- i_trap_valid  input  1  trap/mret entry, from CSR unit.
- i_trap_pc  input  XLEN  trap vector or mepc.
- o_id_valid  output  1  IF/ID holds a valid entry.
- o_id_pc  output  XLEN  PC of IF/ID entry.
- o_id_pc_plus4  output  XLEN  o_id_pc + 4, modulo 2^XLEN.
- o_id_inst  output  INST_WIDTH  instruction of IF/ID entry.
- o_id_exc_valid  output  1  entry carries a fetch exception.
- o_id_exc_cause  output  4  mcause code: 0 = inst addr misaligned, 1 = inst access fault.
- o_fetch_count  output  32  count of non-exception instructions delivered to IF/ID.

Behaviour:
- Reset (i_rst=1 at edge, overrides everything):
  - pc <= RESET_VECTOR; state <= RUN.
  - o_id_valid=0, o_id_pc=0, o_id_pc_plus4=0, o_id_inst=NOP_INST.
  - o_id_exc_valid=0, o_id_exc_cause=0, o_fetch_count=0.
- Fetch checks on current pc, combinational:
  - misaligned = pc[1:0]!=0.
  - fault = pc<INST_MEM_START or pc>INST_MEM_END-3.
  - If both are true, misaligned wins (cause 0).
- Per-edge priority: reset > trap > redirect > stall > normal fetch.
- Trap or redirect, regardless of state or i_stall:
  - pc <= target; IF/ID becomes a bubble: valid=0, inst=NOP_INST, exc_valid=0.
  - state <= RUN.
  - The instruction at the old PC is discarded, so a taken redirect costs one bubble.
  - If trap and redirect are both asserted, the trap target wins.
- Stall (i_stall=1, no trap/redirect): pc, IF/ID, state and counter all hold.
- State RUN, no stall, PC clean:
  - IF/ID <= {valid=1, pc, pc+4, i_imem_inst, exc_valid=0}.
  - pc <= pc+4 (wraps modulo 2^XLEN); o_fetch_count += 1 (wraps).
- State RUN, no stall, PC bad:
  - IF/ID <= {valid=1, pc, pc+4, NOP_INST, exc_valid=1, cause}.
  - pc holds; state <= HALTED; counter holds.
- State HALTED, no stall:
  - IF/ID <= bubble; pc holds.
  - Fetch stays suspended until a trap or redirect arrives.
  - Exit to RUN only via trap or redirect.
- Latency: instruction at pc appears on o_id_* one cycle after the edge that samples it.
- o_imem_addr is always pc, including in HALTED and during reset.
- A misaligned or out-of-range redirect target is accepted. The exception is raised on the next non-stalled fetch cycle.
- Sequential fetch past INST_MEM_END faults with cause 1 at the first out-of-range pc.

Decomposition:
- cotm32_pkg: add fetch_state_e enum {RUN, HALTED}.
- cotm32_pkg: add localparams NOP_INST, EXC_INST_MISALIGNED=4'd0, EXC_INST_ACCESS_FAULT=4'd1.
- cotm32_pkg: add typedef if_id_t (struct of the IF/ID fields) for reuse by the decoder.
- One natural sub-module: fetch_check (combinational misaligned/range check → exc_valid, cause).

Test Plan:
1. Reset, memory preloaded 0x00..0x0C, no stall → o_id_pc 0,4,8,12 on cycles 1–4, o_id_inst matches memory, o_fetch_count=4.
2. i_stall=1 for 3 cycles at pc=8 → o_imem_addr stays 8, o_id_* frozen on previous entry, counter unchanged; release → pc 8 delivered next cycle.
3. i_redirect_valid with i_redirect_pc=0x40 while pc=0x10 → next cycle o_id_valid=0 and o_imem_addr=0x40; cycle after that o_id_pc=0x40. Repeat with i_stall=1 asserted simultaneously → same result.
4. Redirect to 0x42 → o_id_exc_valid=1, cause 0, o_id_pc=0x42, inst=NOP; next cycle o_id_valid=0; pc stays 0x42 until i_trap_valid with i_trap_pc=0x80, which resumes fetch at 0x80.
5. Sequential fetch up to INST_MEM_END-3, then next pc → exception cause 1, state HALTED. Also, trap and redirect asserted together → pc takes i_trap_pc.
6. Assert i_rst mid-run while stalled in HALTED → next cycle pc=RESET_VECTOR, all o_id_* at reset values, counter=0.
